// File: rtl/alb_mss_mem_ibp2sram.sv
// IBP slave that executes buffered IBP bursts, one at a time and in command
// order, against a single-port SRAM with one cycle of read latency.
// Read beats pass through a 3-entry return FIFO that keeps draining after the
// FSM has gone back to IDLE. Write bursts end with a done/error response.
module alb_mss_mem_ibp2sram #(
  parameter int a_w    = 32,
  parameter int d_w    = 32,
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst_b,
  // command channel
  input  logic              ibp_cmd_valid,
  output logic              ibp_cmd_accept,
  input  logic              ibp_cmd_read,
  input  logic [a_w-1:0]    ibp_cmd_addr,
  input  logic              ibp_cmd_wrap,
  input  logic [3:0]        ibp_cmd_burst_size,
  // write-data channel
  input  logic              ibp_wr_valid,
  output logic              ibp_wr_accept,
  input  logic [d_w-1:0]    ibp_wr_data,
  input  logic [d_w/8-1:0]  ibp_wr_mask,
  input  logic              ibp_wr_last,
  // read-data channel
  output logic              ibp_rd_valid,
  input  logic              ibp_rd_accept,
  output logic [d_w-1:0]    ibp_rd_data,
  output logic              ibp_rd_err,
  output logic              ibp_rd_last,
  // write-response channel
  output logic              ibp_wr_done,
  output logic              ibp_err_wr,
  input  logic              ibp_wr_resp_accept,
  // SRAM port
  output logic              mem_cs,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [d_w-1:0]    mem_wdata,
  output logic [d_w/8-1:0]  mem_wmask,
  input  logic [d_w-1:0]    mem_rdata
);

  localparam int BPW     = d_w / 8;
  localparam int LOG_BPW = $clog2(BPW);
  localparam int WA_W    = a_w - LOG_BPW;   // word-address width

  typedef enum logic [1:0] {IDLE, RD, WR, WRSP} state_t;

  state_t            state_reg, state_next;
  logic [WA_W-1:0]   word_reg, word_next;    // current beat word address
  logic [4:0]        len_reg, len_next;      // expected beats, 1..16
  logic              wrap_reg, wrap_next;
  logic [4:0]        cnt_reg, cnt_next;      // beats issued / accepted so far
  logic              err_reg, err_next;      // sticky write error

  // read issue pipeline (one beat in flight towards the FIFO)
  logic              issue, issue_err, issue_last;
  logic              inflight_reg, inflight_err_reg, inflight_last_reg;

  // read return FIFO
  logic [d_w-1:0]    fifo_data [3];
  logic              fifo_err  [3];
  logic              fifo_last [3];
  logic [1:0]        fifo_cnt_reg, wr_ptr_reg, rd_ptr_reg;
  logic              push, pop, can_issue;
  logic [2:0]        used;
  logic [d_w-1:0]    push_data;

  logic              in_range, last_beat;
  logic              unused_addr_bits;

  // byte-offset bits below the word address carry no meaning here
  assign unused_addr_bits = ^ibp_cmd_addr[LOG_BPW-1:0];

  // next beat address: incrementing, or wrapping inside a 2/4/8/16-beat window
  function automatic logic [WA_W-1:0] step(input logic [WA_W-1:0] w,
                                           input logic wr,
                                           input logic [4:0] n);
    logic [WA_W-1:0] inc, msk;
    inc = w + WA_W'(1);
    msk = WA_W'(n) - WA_W'(1);
    if (wr && (n == 5'd2 || n == 5'd4 || n == 5'd8 || n == 5'd16))
      return (w & ~msk) | (inc & msk);
    return inc;
  endfunction

  assign in_range  = ~|word_reg[WA_W-1:MEM_AW];
  assign last_beat = (cnt_reg == len_reg - 5'd1);

  assign pop       = ibp_rd_valid & ibp_rd_accept;
  assign push      = inflight_reg;
  assign push_data = inflight_err_reg ? '0 : mem_rdata;
  // a slot freed by this cycle's pop can be reused by this cycle's issue
  assign used      = {1'b0, fifo_cnt_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign can_issue = (used < 3'd3);

  assign ibp_rd_valid = (fifo_cnt_reg != 2'd0);
  assign ibp_rd_data  = ibp_rd_valid ? fifo_data[rd_ptr_reg] : '0;
  assign ibp_rd_err   = ibp_rd_valid & fifo_err[rd_ptr_reg];
  assign ibp_rd_last  = ibp_rd_valid & fifo_last[rd_ptr_reg];

  // next-state, burst bookkeeping and SRAM/handshake outputs
  always_comb begin
    state_next     = state_reg;
    word_next      = word_reg;
    len_next       = len_reg;
    wrap_next      = wrap_reg;
    cnt_next       = cnt_reg;
    err_next       = err_reg;
    ibp_cmd_accept = 1'b0;
    ibp_wr_accept  = 1'b0;
    ibp_wr_done    = 1'b0;
    ibp_err_wr     = 1'b0;
    mem_cs         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_wmask      = '0;
    issue          = 1'b0;
    issue_err      = 1'b0;
    issue_last     = 1'b0;
    case (state_reg)
      IDLE: begin
        ibp_cmd_accept = 1'b1;
        if (ibp_cmd_valid) begin
          word_next  = ibp_cmd_addr[a_w-1:LOG_BPW];
          len_next   = {1'b0, ibp_cmd_burst_size} + 5'd1;
          wrap_next  = ibp_cmd_wrap;
          cnt_next   = '0;
          state_next = ibp_cmd_read ? RD : WR;
        end
      end
      RD: begin
        if (can_issue) begin
          issue      = 1'b1;
          issue_err  = ~in_range;
          issue_last = last_beat;
          if (in_range) begin
            mem_cs   = 1'b1;
            mem_addr = word_reg[MEM_AW-1:0];
          end
          word_next = step(word_reg, wrap_reg, len_reg);
          cnt_next  = cnt_reg + 5'd1;
          if (last_beat)
            state_next = IDLE;
        end
      end
      WR: begin
        ibp_wr_accept = 1'b1;
        if (ibp_wr_valid) begin
          if (in_range) begin
            mem_cs    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = word_reg[MEM_AW-1:0];
            mem_wdata = ibp_wr_data;
            mem_wmask = ibp_wr_mask;
          end else begin
            err_next = 1'b1;
          end
          // a beat beyond the expected count is already a length error
          if (cnt_reg >= len_reg)
            err_next = 1'b1;
          word_next = step(word_reg, wrap_reg, len_reg);
          cnt_next  = (cnt_reg == 5'd31) ? cnt_reg : cnt_reg + 5'd1;
          if (ibp_wr_last) begin
            if (!last_beat)
              err_next = 1'b1;
            state_next = WRSP;
          end
        end
      end
      WRSP: begin
        ibp_wr_done = ~err_reg;
        ibp_err_wr  = err_reg;
        if (ibp_wr_resp_accept) begin
          err_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM and burst registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg <= IDLE;
      word_reg  <= '0;
      len_reg   <= '0;
      wrap_reg  <= 1'b0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      word_reg  <= word_next;
      len_reg   <= len_next;
      wrap_reg  <= wrap_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  // in-flight beat tracking: SRAM data arrives the cycle after issue
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      inflight_reg      <= 1'b0;
      inflight_err_reg  <= 1'b0;
      inflight_last_reg <= 1'b0;
    end else begin
      inflight_reg      <= issue;
      inflight_err_reg  <= issue_err;
      inflight_last_reg <= issue_last;
    end
  end

  // FIFO occupancy and pointers; simultaneous push and pop keeps the count
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      fifo_cnt_reg <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= (wr_ptr_reg == 2'd2) ? 2'd0 : wr_ptr_reg + 2'd1;
      if (pop)
        rd_ptr_reg <= (rd_ptr_reg == 2'd2) ? 2'd0 : rd_ptr_reg + 2'd1;
      case ({push, pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 2'd1;
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 2'd1;
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  // FIFO storage; contents are only observed while the count covers them
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr_reg] <= push_data;
      fifo_err[wr_ptr_reg]  <= inflight_err_reg;
      fifo_last[wr_ptr_reg] <= inflight_last_reg;
    end
  end

endmodule

// File: tb/tb_alb_mss_mem_ibp2sram.sv
// Self-checking bench for alb_mss_mem_ibp2sram: directed bursts followed by
// randomized traffic, compared against a byte-level reference memory and the
// burst address rules computed arithmetically.
module tb_alb_mss_mem_ibp2sram;

  localparam int MEMW = 1024;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        ibp_cmd_valid, ibp_cmd_accept, ibp_cmd_read, ibp_cmd_wrap;
  logic [31:0] ibp_cmd_addr;
  logic [3:0]  ibp_cmd_burst_size;
  logic        ibp_wr_valid, ibp_wr_accept, ibp_wr_last;
  logic [31:0] ibp_wr_data;
  logic [3:0]  ibp_wr_mask;
  logic        ibp_rd_valid, ibp_rd_accept, ibp_rd_err, ibp_rd_last;
  logic [31:0] ibp_rd_data;
  logic        ibp_wr_done, ibp_err_wr, ibp_wr_resp_accept;
  logic        mem_cs, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  logic [31:0] sram    [MEMW];
  logic [31:0] ref_mem [MEMW];
  logic [9:0]  cs_addrs [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          outstanding;

  alb_mss_mem_ibp2sram dut (
    .clk(clk), .rst_b(rst_b),
    .ibp_cmd_valid(ibp_cmd_valid), .ibp_cmd_accept(ibp_cmd_accept),
    .ibp_cmd_read(ibp_cmd_read), .ibp_cmd_addr(ibp_cmd_addr),
    .ibp_cmd_wrap(ibp_cmd_wrap), .ibp_cmd_burst_size(ibp_cmd_burst_size),
    .ibp_wr_valid(ibp_wr_valid), .ibp_wr_accept(ibp_wr_accept),
    .ibp_wr_data(ibp_wr_data), .ibp_wr_mask(ibp_wr_mask), .ibp_wr_last(ibp_wr_last),
    .ibp_rd_valid(ibp_rd_valid), .ibp_rd_accept(ibp_rd_accept),
    .ibp_rd_data(ibp_rd_data), .ibp_rd_err(ibp_rd_err), .ibp_rd_last(ibp_rd_last),
    .ibp_wr_done(ibp_wr_done), .ibp_err_wr(ibp_err_wr),
    .ibp_wr_resp_accept(ibp_wr_resp_accept),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM behaviour: one-cycle read latency, byte-masked writes
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // read credit monitor: in-range beats issued but not yet returned never exceed 3
  always begin
    @(negedge clk);
    #2;
    if (!rst_b) begin
      outstanding = 0;
    end else begin
      int pop_ok;
      pop_ok = (ibp_rd_valid && ibp_rd_accept && !ibp_rd_err) ? 1 : 0;
      if (mem_cs && !mem_we) begin
        check("credit_limit", 128'((outstanding - pop_ok) < 3), 128'd1);
        cs_addrs.push_back(mem_addr);
        outstanding++;
      end
      outstanding -= pop_ok;
    end
  end

  // word address of beat i, derived from the burst rules
  function automatic logic [29:0] beat_word(input logic [29:0] start, input logic wrap,
                                            input int len, input int i);
    logic [29:0] l, off;
    l = 30'(len);
    if (wrap && (len == 2 || len == 4 || len == 8 || len == 16)) begin
      off = start % l;
      return (start - off) + ((off + 30'(i)) % l);
    end
    return start + 30'(i);
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_ctrl"}, 128'({ibp_cmd_accept, ibp_wr_accept, ibp_rd_valid, ibp_rd_err,
                                ibp_rd_last, ibp_wr_done, ibp_err_wr, mem_cs, mem_we}),
          128'(9'b100000000));
    check({tag, "_rd_data"}, 128'(ibp_rd_data), 128'd0);
    check({tag, "_mem_bus"}, 128'({mem_addr, mem_wdata, mem_wmask}), 128'd0);
  endtask

  // present a command and return at the negedge of the cycle after the handshake
  task automatic send_cmd(input logic rd, input logic [31:0] addr, input int bsz, input logic wrap);
    int n = 0;
    ibp_cmd_valid = 1'b1; ibp_cmd_read = rd; ibp_cmd_addr = addr;
    ibp_cmd_wrap = wrap; ibp_cmd_burst_size = 4'(bsz);
    while (!ibp_cmd_accept && n < 100) begin @(negedge clk); n++; end
    check("cmd_accept", 128'(ibp_cmd_accept), 128'd1);
    @(negedge clk);
    ibp_cmd_valid = 1'b0;
    check("cmd_accept_busy", 128'(ibp_cmd_accept), 128'd0);
  endtask

  task automatic do_write(input logic [31:0] addr, input int bsz, input logic wrap,
                          input int nbeats, input int resp_dly, input logic fixed);
    int len = bsz + 1;
    logic exp_err = (nbeats != len);
    logic [29:0] start = addr[31:2];
    logic [29:0] w;
    int n;
    send_cmd(1'b0, addr, bsz, wrap);
    check("wr_accept_c1", 128'(ibp_wr_accept), 128'd1);
    for (int i = 0; i < nbeats; i++) begin
      if (!fixed && ($urandom % 3 == 0)) begin
        ibp_wr_valid = 1'b0;
        @(negedge clk);
      end
      ibp_wr_valid = 1'b1;
      ibp_wr_data  = fixed ? 32'hA0 + 32'(i) : $urandom;
      ibp_wr_mask  = (fixed || $urandom % 2 == 0) ? 4'hF : 4'($urandom);
      ibp_wr_last  = (i == nbeats - 1);
      n = 0;
      while (!ibp_wr_accept && n < 100) begin @(negedge clk); n++; end
      check("wr_accept", 128'(ibp_wr_accept), 128'd1);
      w = beat_word(start, wrap, len, i);
      if (w < 30'(MEMW)) begin
        for (int b = 0; b < 4; b++)
          if (ibp_wr_mask[b]) ref_mem[w[9:0]][8*b +: 8] = ibp_wr_data[8*b +: 8];
      end else begin
        exp_err = 1'b1;
      end
      @(negedge clk);
    end
    ibp_wr_valid = 1'b0; ibp_wr_last = 1'b0;
    for (int d = 0; d <= resp_dly; d++) begin
      check("wr_done", 128'(ibp_wr_done), 128'(!exp_err));
      check("wr_err", 128'(ibp_err_wr), 128'(exp_err));
      if (d == resp_dly) ibp_wr_resp_accept = 1'b1;
      @(negedge clk);
    end
    ibp_wr_resp_accept = 1'b0;
    check("idle_after_resp", 128'({ibp_cmd_accept, ibp_wr_done, ibp_err_wr}), 128'(3'b100));
    $display("WR addr=%08h bsz=%0d wrap=%0d beats=%0d exp_err=%0d", addr, bsz, wrap, nbeats, exp_err);
  endtask

  // mode 0: rd_accept high; 1: low for the first 5 cycles; 2: random
  task automatic do_read(input logic [31:0] addr, input int bsz, input logic wrap, input int mode);
    int len = bsz + 1;
    logic [29:0] start = addr[31:2];
    logic [29:0] w;
    logic [31:0] exp_d [$];
    logic        exp_e [$];
    logic [9:0]  exp_a [$];
    int k = 0, cyc = 1, first_valid = -1, bad = 0;
    logic prev_hold = 1'b0;
    for (int i = 0; i < len; i++) begin
      w = beat_word(start, wrap, len, i);
      if (w < 30'(MEMW)) begin
        exp_d.push_back(ref_mem[w[9:0]]); exp_e.push_back(1'b0); exp_a.push_back(w[9:0]);
      end else begin
        exp_d.push_back(32'd0); exp_e.push_back(1'b1);
      end
    end
    cs_addrs.delete();
    ibp_rd_accept = (mode != 1);
    send_cmd(1'b1, addr, bsz, wrap);
    while (k < len && cyc < 300) begin
      if (mode == 1) ibp_rd_accept = (cyc >= 6);
      else if (mode == 2) ibp_rd_accept = 1'($urandom % 2);
      if (prev_hold) check("rd_valid_held", 128'(ibp_rd_valid), 128'd1);
      if (ibp_rd_valid) begin
        if (first_valid < 0) first_valid = cyc;
        check("rd_data", 128'(ibp_rd_data), 128'(exp_d[k]));
        check("rd_err", 128'(ibp_rd_err), 128'(exp_e[k]));
        check("rd_last", 128'(ibp_rd_last), 128'(k == len - 1));
        if (ibp_rd_accept) k++;
      end
      prev_hold = ibp_rd_valid && !ibp_rd_accept;
      @(negedge clk);
      cyc++;
    end
    check("rd_beats", 128'(k), 128'(len));
    if (mode == 0) check("rd_latency", 128'(first_valid), 128'(3));
    check("rd_drained", 128'(ibp_rd_valid), 128'd0);
    check("cs_count", 128'(cs_addrs.size()), 128'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < cs_addrs.size(); i++)
      if (cs_addrs[i] !== exp_a[i]) bad++;
    check("cs_addr_seq", 128'(bad), 128'd0);
    $display("RD addr=%08h bsz=%0d wrap=%0d mode=%0d beats=%0d", addr, bsz, wrap, mode, k);
  endtask

  function automatic logic [31:0] pick_addr();
    logic [29:0] w;
    case ($urandom % 4)
      0, 1, 2: w = 30'($urandom % MEMW);
      default: w = ($urandom % 2 == 0) ? 30'(1020 + $urandom % 8)
                                       : 30'h3FFFFFFC + 30'($urandom % 4);
    endcase
    return {w, 2'($urandom)};
  endfunction

  initial begin
    int bsz, nb, mode;
    int bad;
    logic [31:0] a;
    logic wrap;
    for (int i = 0; i < MEMW; i++) begin
      sram[i] = $urandom;
      ref_mem[i] = sram[i];
    end
    rst_b = 1'b0;
    ibp_cmd_valid = 0; ibp_cmd_read = 0; ibp_cmd_addr = 0; ibp_cmd_wrap = 0;
    ibp_cmd_burst_size = 0; ibp_wr_valid = 0; ibp_wr_data = 32'h5A5A5A5A;
    ibp_wr_mask = 4'hF; ibp_wr_last = 0; ibp_rd_accept = 0; ibp_wr_resp_accept = 0;
    @(negedge clk);
    check_reset("por");
    @(negedge clk);
    rst_b = 1'b1;

    // directed bursts
    do_write(32'h100, 3, 1'b0, 4, 1, 1'b1);
    do_read(32'h100, 3, 1'b0, 0);
    do_read(32'h108, 3, 1'b1, 0);
    do_read(32'h1000, 1, 1'b0, 0);
    do_read(32'h100, 3, 1'b0, 1);
    do_write(32'h200, 3, 1'b0, 2, 2, 1'b0);
    do_read(32'h0FF0, 7, 1'b0, 2);

    // reset in the middle of a read burst
    ibp_rd_accept = 1'b0;
    send_cmd(1'b1, 32'h100, 7, 1'b0);
    repeat (3) @(negedge clk);
    #3 rst_b = 1'b0;
    #1 check_reset("mid_burst");
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    $display("RST mid read burst");
    do_read(32'h100, 3, 1'b0, 0);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      a = pick_addr();
      bsz = $urandom % 16;
      wrap = 1'($urandom % 2);
      if ($urandom % 2 == 0) begin
        nb = ($urandom % 5 == 0) ? 1 + $urandom % 18 : bsz + 1;
        do_write(a, bsz, wrap, nb, $urandom % 4, 1'b0);
      end else begin
        mode = $urandom % 3;
        do_read(a, bsz, wrap, mode);
      end
    end

    bad = 0;
    for (int i = 0; i < MEMW; i++)
      if (sram[i] !== ref_mem[i]) bad++;
    check("mem_contents", 128'(bad), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
